seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
// - Multicycle signed integer divider for the processor's multdiv unit; it complements the CLA adder blocks.
// - Restoring algorithm: 1 quotient bit/cycle, built on a WIDTH+1 bit subtractor computed as A + ~B + 1.
// - Started by a one-cycle ctrl_div pulse from the execute stage; returns quotient plus a one-cycle ready pulse.
// PARAMETERS
// - WIDTH  32  operand/result width in bits; two's complement; must be >= 4
// PORTS
// - clock             in   1      single clock; all state updates on rising edge
// - reset             in   1      asynchronous, active-low; 0 forces the reset state immediately
// - ctrl_div          in   1      start pulse; operands sampled on the same edge
// - data_operandA     in   WIDTH  dividend (signed)
// - data_operandB     in   WIDTH  divisor (signed)
// - data_result       out  WIDTH  quotient; registered; held until next start/reset
// - data_exception    out  1      divide-by-zero flag; registered; held with data_result
// - data_resultRDY    out  1      high for exactly 1 cycle when result is valid
// - busy              out  1      high while state != IDLE
// - data_remainder    out  WIDTH  remainder (only when REMAINDER_OUT_EN is defined)
// BEHAVIOUR
// - Reset (reset=0): state=IDLE; count=0; data_result=0; data_exception=0; data_resultRDY=0; busy=0; data_remainder=0.
// - FSM: IDLE -> RUN on ctrl_div. RUN lasts WIDTH edges, then -> DONE. DONE -> IDLE on the next edge.
// - Load (edge k, ctrl_div=1): latch |A| and |B| as unsigned.
//   - Latch sign_q = A[WIDTH-1]^B[WIDTH-1] and sign_r = A[WIDTH-1].
//   - Latch div0 = (B==0). Clear the WIDTH+1 bit partial remainder. count=0.
// - Iteration (edges k+1..k+WIDTH): shift {rem,quo} left 1, bringing in the next dividend MSB.
//   - Compute diff = rem - |B| over WIDTH+1 bits.
//   - If diff >= 0: rem=diff and quotient LSB=1; otherwise rem is kept and the LSB=0.
// - Edge k+WIDTH: final iteration completes and the state goes to DONE.
//   - data_result = sign_q ? -quo : quo. data_remainder = sign_r ? -rem : rem.
//   - data_exception = div0. data_resultRDY=1 for the cycle after edge k+WIDTH only.
// - Latency: ready is seen WIDTH cycles after the sampling edge. Issue rate is 1 per WIDTH+1 cycles.
// - Arithmetic rules:
//   - Quotient truncates toward zero; the remainder takes the sign of the dividend.
//   - |MIN| is handled as unsigned 2^(WIDTH-1).
//   - MIN / -1 wraps to MIN with data_exception=0.
// - Divide by zero: same latency; data_result=0, data_remainder=0, data_exception=1.
// - ctrl_div during RUN or DONE: the current operation is abandoned and the new operands are loaded (restart).
//   - No data_resultRDY is given for the abandoned operation.
// - ctrl_div in the same cycle as data_resultRDY: this cycle's ready is still given, and the new operation loads.
// - data_result and data_exception change only on the DONE-entry edge or on reset.
// - Reset mid-operation: immediate abort to the reset state; no ready pulse.
// - Operand inputs are ignored outside the load edge.
// CONFIGURATION
// - REMAINDER_OUT_EN defined: the data_remainder port exists and is driven as described above.
// - REMAINDER_OUT_EN undefined: the port is absent and the remainder-correction negator is removed.
//   - Quotient timing and values are identical in both builds.
// TESTING
// - 100 / 7 pulsed at edge k:
//   - data_resultRDY=1 only in the cycle after edge k+WIDTH.
//   - result=14, exception=0; remainder=2 if REMAINDER_OUT_EN.
// - -100 / 7 -> result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
// - 100 / -7 -> result=-14, remainder=+2.
// - 1234 / 0 -> result=0, exception=1, ready after the same WIDTH-cycle latency.
// - 0x80000000 / 0xFFFFFFFF -> result=0x80000000, exception=0.
// - 0x80000000 / 1 -> result=0x80000000.
// - Start 50/5, re-pulse ctrl_div with 81/9 at edge k+10:
//   - Exactly one ready pulse, at edge k+10+WIDTH, with result=9.
// - Drop reset for 1 cycle at edge k+5 of an operation:
//   - Outputs go to 0 at once, busy=0, and no ready pulse follows.
//   - A later 9/3 returns 3.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed restoring divider, one quotient bit per cycle.
// Optional remainder output is enabled by defining REMAINDER_OUT_EN.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef REMAINDER_OUT_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic             sign_q, div0;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic             last;
`ifdef REMAINDER_OUT_EN
  logic             sign_r;
`endif

  // Operand magnitudes and one restoring step over a WIDTH+1 bit subtractor
  always_comb begin
    abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted + ~{1'b0, dvs} + (WIDTH+1)'(1);
    quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
    rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    last    = (count == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and status outputs; a start pulse always (re)loads
  always_comb begin
    state_nxt      = state;
    data_resultRDY = (state == DONE);
    busy           = (state != IDLE);
    if (ctrl_div) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     state_nxt = last ? DONE : RUN;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: load on start, iterate in RUN, publish results on the final step
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count          <= '0;
      quo            <= '0;
      rem            <= '0;
      dvs            <= '0;
      sign_q         <= 1'b0;
      div0           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
`ifdef REMAINDER_OUT_EN
      sign_r         <= 1'b0;
      data_remainder <= '0;
`endif
    end else if (ctrl_div) begin
      count  <= '0;
      quo    <= abs_a;
      rem    <= '0;
      dvs    <= abs_b;
      sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div0   <= (data_operandB == '0);
`ifdef REMAINDER_OUT_EN
      sign_r <= data_operandA[WIDTH-1];
`endif
    end else if (state == RUN) begin
      quo   <= quo_nxt;
      rem   <= rem_nxt;
      count <= count + CW'(1);
      if (last) begin
        data_result    <= div0 ? '0 : (sign_q ? -quo_nxt : quo_nxt);
        data_exception <= div0;
`ifdef REMAINDER_OUT_EN
        data_remainder <= div0 ? '0 : (sign_r ? -rem_nxt : rem_nxt);
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an arithmetic model.
module tb_seq_divider;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_div;
  logic [W-1:0] data_operandA, data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, busy;
`ifdef REMAINDER_OUT_EN
  logic [W-1:0] data_remainder;
`endif

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
`ifdef REMAINDER_OUT_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed division in 64-bit arithmetic: truncation toward zero, remainder follows dividend
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic e);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = '0; r = '0; e = 1'b1;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); e = 1'b0;
    end
  endfunction

  // Called at a negedge: pulse start for one cycle, then scramble operands
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_div = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_div = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called at the negedge after the load edge; ends at the negedge where ready is high
  task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] q, r, held;
    logic         e;
    ref_div(a, b, q, r, e);
    held = data_result;
    for (int i = 1; i < W; i++) begin
      @(negedge clock);
      chk({tag, ".rdy_early"}, data_resultRDY, 1'b0);
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".held"}, data_result, held);
    end
    @(negedge clock);
    chk({tag, ".rdy"}, data_resultRDY, 1'b1);
    chk({tag, ".quo"}, data_result, q);
    chk({tag, ".exc"}, data_exception, e);
`ifdef REMAINDER_OUT_EN
    chk({tag, ".rem"}, data_remainder, r);
`endif
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    chk({tag, ".rdy_after"}, data_resultRDY, 1'b0);
    chk({tag, ".busy_after"}, busy, 1'b0);
  endtask

  logic [W-1:0] da [7] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'd1234,
                           32'h8000_0000, 32'h8000_0000, 32'd9};
  logic [W-1:0] db [7] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0,
                           32'hFFFF_FFFF, 32'd1, 32'd3};

  initial begin
    logic [W-1:0] ra, rb;
    reset = 1'b0;
    ctrl_div = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    chk("reset.quo", data_result, '0);
    chk("reset.exc", data_exception, 1'b0);
    chk("reset.rdy", data_resultRDY, 1'b0);
    chk("reset.busy", busy, 1'b0);
`ifdef REMAINDER_OUT_EN
    chk("reset.rem", data_remainder, '0);
`endif
    reset = 1'b1;
    @(negedge clock);

    // Directed cases, including divide-by-zero and MIN corner cases
    for (int i = 0; i < 7; i++) begin
      launch(da[i], db[i]);
      wait_result(da[i], db[i], $sformatf("dir%0d", i));
      check_idle($sformatf("dir%0d", i));
    end

    // Spec constants cross-checked independently of the model
    launch(32'd100, 32'd7);
    wait_result(32'd100, 32'd7, "c100_7");
    chk("const100_7", data_result, 32'd14);
    check_idle("c100_7");

    // New start in the ready cycle: ready still seen, new operation loads
    launch(32'd7, 32'd2);
    wait_result(32'd7, 32'd2, "b2b_a");
    launch(32'hFFFF_FFCE, 32'hFFFF_FFFA);
    wait_result(32'hFFFF_FFCE, 32'hFFFF_FFFA, "b2b_b");
    check_idle("b2b_b");

    // Restart at edge k+10: only the second operation produces ready
    launch(32'd50, 32'd5);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      chk("restart.rdy_early", data_resultRDY, 1'b0);
    end
    launch(32'd81, 32'd9);
    wait_result(32'd81, 32'd9, "restart");
    chk("restart.const", data_result, 32'd9);
    check_idle("restart");

    // Asynchronous reset at edge k+5 aborts the operation immediately
    launch(32'd12345, 32'd17);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("arst.quo", data_result, '0);
    chk("arst.exc", data_exception, 1'b0);
    chk("arst.rdy", data_resultRDY, 1'b0);
    chk("arst.busy", busy, 1'b0);
`ifdef REMAINDER_OUT_EN
    chk("arst.rem", data_remainder, '0);
`endif
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clock);
      chk("arst.no_rdy", data_resultRDY, 1'b0);
      chk("arst.idle", busy, 1'b0);
    end
    launch(32'd9, 32'd3);
    wait_result(32'd9, 32'd3, "post_rst");
    chk("post_rst.const", data_result, 32'd3);
    check_idle("post_rst");

    // Random operands, mixing full-range and small divisors
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = W'($signed(8'($urandom)));
        1:       rb = W'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      launch(ra, rb);
      wait_result(ra, rb, $sformatf("rnd%0d", i));
      check_idle($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
